// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle MIPS PC sequencer FSM with branch/jump resolution, link requests and halt-on-jump-to-zero.
// Optional PC_ALIGN_CHECK_EN: misaligned JR/JALR targets halt and raise misaligned_err instead of being truncated.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        waitrequest,
  input  logic [31:0] pc_curr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [2:0]  state,
  output logic        pcctl,
  output logic        PCWriteCond,
  output logic [31:0] pc_prev,
  output logic        link_en,
  output logic [4:0]  link_reg,
  output logic [31:0] link_addr,
  output logic        active,
  output logic        misaligned_err
);
  typedef enum logic [2:0] {
    FETCH_INSTR   = 3'd0,
    DECODE        = 3'd1,
    EXECUTE       = 3'd2,
    MEMORY_ACCESS = 3'd3,
    WRITE_BACK    = 3'd4,
    HALTED        = 3'd5
  } state_t;
  state_t st;
  logic [31:0] ir, br_target, jmp_target, reg_target, target;
  logic [5:0] op, fn;
  logic [4:0] rt_f;
  logic is_jr, is_jalr, is_jreg, is_j, is_jal, is_bltz, is_bgez, is_bltzal, is_bgezal;
  logic is_link, is_mem, rs_neg, rs_zero, rs_eq, taken, bad_align, halt_hit;
  logic halt_pending, halt_armed, link_v;
  assign op         = ir[31:26];
  assign fn         = ir[5:0];
  assign rt_f       = ir[20:16];
  assign is_jr      = op == 6'd0 && fn == 6'h08;
  assign is_jalr    = op == 6'd0 && fn == 6'h09;
  assign is_jreg    = is_jr | is_jalr;
  assign is_j       = op == 6'd2;
  assign is_jal     = op == 6'd3;
  assign is_bltz    = op == 6'd1 && rt_f == 5'h00;
  assign is_bgez    = op == 6'd1 && rt_f == 5'h01;
  assign is_bltzal  = op == 6'd1 && rt_f == 5'h10;
  assign is_bgezal  = op == 6'd1 && rt_f == 5'h11;
  assign is_link    = is_jal | is_jalr | is_bltzal | is_bgezal;
  assign is_mem     = op >= 6'h20 && op <= 6'h2B;
  assign rs_neg     = rs_data[31];
  assign rs_zero    = rs_data == 32'd0;
  assign rs_eq      = rs_data == rt_data;
  assign taken      = (op == 6'd4 && rs_eq) | (op == 6'd5 && !rs_eq) |
                      (op == 6'd6 && (rs_neg | rs_zero)) | (op == 6'd7 && !rs_neg && !rs_zero) |
                      ((is_bltz | is_bltzal) && rs_neg) | ((is_bgez | is_bgezal) && !rs_neg) |
                      is_j | is_jal | is_jreg;
  assign br_target  = pc_curr + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign jmp_target = {pc_curr[31:28], ir[25:0], 2'b00};
  assign reg_target = {rs_data[31:2], 2'b00};
  assign target     = is_jreg ? reg_target : (is_j | is_jal) ? jmp_target : br_target;
`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;
  assign bad_align      = is_jreg && rs_data[1:0] != 2'b00;
  assign misaligned_err = mis_q;
`else
  assign bad_align      = 1'b0;
  assign misaligned_err = 1'b0;
`endif
  assign halt_hit    = is_jreg && reg_target == 32'd0 && !bad_align;
  assign state       = st;
  assign active      = st != HALTED;
  assign pcctl       = st == FETCH_INSTR && !waitrequest && !reset;
  assign PCWriteCond = st == EXECUTE && taken && !bad_align && !reset;
  assign pc_prev     = pcctl ? pc_curr + 32'd4 : PCWriteCond ? target : 32'd0;
  assign link_en     = st == WRITE_BACK && link_v && !reset;
  // halt_pending marks the jump; halt_armed carries it past the jump's own write-back so the delay slot completes first
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= FETCH_INSTR;
      ir           <= 32'd0;
      halt_pending <= 1'b0;
      halt_armed   <= 1'b0;
      link_v       <= 1'b0;
      link_reg     <= 5'd0;
      link_addr    <= 32'd0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q        <= 1'b0;
`endif
    end else begin
      case (st)
        FETCH_INSTR: if (!waitrequest) begin
          ir <= instr;
          st <= DECODE;
        end
        DECODE: st <= EXECUTE;
        EXECUTE: begin
          link_v    <= is_link;
          link_reg  <= is_jalr ? ir[15:11] : 5'd31;
          link_addr <= pc_curr + 32'd4;
          if (halt_hit) halt_pending <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          if (bad_align) mis_q <= 1'b1;
`endif
          st <= bad_align ? HALTED : MEMORY_ACCESS;
        end
        MEMORY_ACCESS: if (!(is_mem && waitrequest)) st <= WRITE_BACK;
        WRITE_BACK: begin
          st           <= halt_armed ? HALTED : FETCH_INSTR;
          halt_armed   <= halt_pending;
          halt_pending <= 1'b0;
        end
        default: st <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer; inputs driven and outputs sampled just after the falling edge.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, waitrequest, pcctl, PCWriteCond, link_en, active, misaligned_err;
  logic [31:0] instr, pc_curr, rs_data, rt_data, pc_prev, link_addr;
  logic [2:0]  state;
  logic [4:0]  link_reg;
  int nchk = 0;
  int nfail = 0;
  pc_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .waitrequest(waitrequest), .pc_curr(pc_curr),
    .rs_data(rs_data), .rt_data(rt_data), .state(state), .pcctl(pcctl), .PCWriteCond(PCWriteCond),
    .pc_prev(pc_prev), .link_en(link_en), .link_reg(link_reg), .link_addr(link_addr),
    .active(active), .misaligned_err(misaligned_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] ins, input logic [31:0] addr);
    instr = ins; pc_curr = addr; waitrequest = 1'b0;
    #1;
    chk("fetch_state", 32'(state), 32'd0);
    chk("fetch_pcctl", 32'(pcctl), 32'd1);
    chk("fetch_pc_prev", pc_prev, addr + 32'd4);
    chk("fetch_no_cond", 32'(PCWriteCond), 32'd0);
    step;
    instr = 32'hDEADBEEF; pc_curr = addr + 32'd4;
    #1;
    chk("decode_state", 32'(state), 32'd1);
    chk("decode_no_strobe", 32'(pcctl | PCWriteCond), 32'd0);
    step;
    chk("execute_state", 32'(state), 32'd2);
  endtask
  task automatic to_wb(input logic stall, input logic le, input logic [4:0] lr, input logic [31:0] la);
    waitrequest = stall;
    step;
    chk("mem_state", 32'(state), 32'd3);
    chk("mem_no_strobe", 32'(pcctl | PCWriteCond), 32'd0);
    step;
    chk("wb_state", 32'(state), 32'd4);
    chk("wb_link_en", 32'(link_en), 32'(le));
    if (le) begin
      chk("wb_link_reg", 32'(link_reg), 32'(lr));
      chk("wb_link_addr", link_addr, la);
    end
    waitrequest = 1'b0;
  endtask
  initial begin
    reset = 1'b1; waitrequest = 1'b0; instr = 32'd0; pc_curr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    step; step;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_no_pcctl", 32'(pcctl), 32'd0);
    chk("reset_active", 32'(active), 32'd1);
    chk("reset_mis", 32'(misaligned_err), 32'd0);
    chk("reset_link_en", 32'(link_en), 32'd0);
    // fetch stall for three cycles
    reset = 1'b0; waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stall_state", 32'(state), 32'd0);
      chk("stall_pcctl", 32'(pcctl), 32'd0);
    end
    fetch(32'h00000000, 32'h00000000);
    chk("nop_no_cond", 32'(PCWriteCond), 32'd0);
    chk("nop_pc_prev", pc_prev, 32'd0);
    to_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step; chk("nop_next_fetch", 32'(state), 32'd0);
    // BEQ backwards, taken then not taken
    fetch(32'h1022FFFF, 32'h000000FC);
    rs_data = 32'd5; rt_data = 32'd5; #1;
    chk("beq_taken_cond", 32'(PCWriteCond), 32'd1);
    chk("beq_taken_target", pc_prev, 32'h000000FC);
    chk("beq_taken_no_pcctl", 32'(pcctl), 32'd0);
    to_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step;
    fetch(32'h1022FFFF, 32'h000000FC);
    rt_data = 32'd6; #1;
    chk("beq_nt_cond", 32'(PCWriteCond), 32'd0);
    chk("beq_nt_pc_prev", pc_prev, 32'd0);
    to_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step;
    // JAL, with a memory-phase waitrequest that must be ignored
    fetch(32'h0C000040, 32'h10000004);
    #1;
    chk("jal_cond", 32'(PCWriteCond), 32'd1);
    chk("jal_target", pc_prev, 32'h10000100);
    to_wb(1'b1, 1'b1, 5'd31, 32'h1000000C);
    step; chk("jal_next_fetch", 32'(state), 32'd0);
    // BGEZAL on a negative value: not taken but still links
    fetch(32'h04710004, 32'h00000040);
    rs_data = 32'hFFFFFFFF; #1;
    chk("bgezal_nt_cond", 32'(PCWriteCond), 32'd0);
    to_wb(1'b0, 1'b1, 5'd31, 32'h00000048);
    step;
    // BLTZ on most-negative value
    fetch(32'h04600002, 32'h00000200);
    rs_data = 32'h80000000; #1;
    chk("bltz_cond", 32'(PCWriteCond), 32'd1);
    chk("bltz_target", pc_prev, 32'h0000020C);
    to_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step;
    // BGTZ with zero is not taken
    fetch(32'h1C600010, 32'h00000240);
    rs_data = 32'd0; #1;
    chk("bgtz_zero_cond", 32'(PCWriteCond), 32'd0);
    to_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step;
    // JALR links to rd
    fetch(32'h00202809, 32'h00000300);
    rs_data = 32'h00000500; #1;
    chk("jalr_cond", 32'(PCWriteCond), 32'd1);
    chk("jalr_target", pc_prev, 32'h00000500);
    to_wb(1'b0, 1'b1, 5'd5, 32'h00000308);
    step;
    // LW stalled in memory access, reset during the stall
    fetch(32'h8C220000, 32'h00000400);
    #1;
    chk("lw_no_cond", 32'(PCWriteCond), 32'd0);
    waitrequest = 1'b1;
    step; chk("lw_mem_state", 32'(state), 32'd3);
    step; chk("lw_mem_hold", 32'(state), 32'd3);
    reset = 1'b1; #1;
    chk("lw_reset_pcctl", 32'(pcctl), 32'd0);
    chk("lw_reset_cond", 32'(PCWriteCond), 32'd0);
    chk("lw_reset_link", 32'(link_en), 32'd0);
    chk("lw_reset_pc_prev", pc_prev, 32'd0);
    step; chk("lw_reset_state", 32'(state), 32'd0);
    reset = 1'b0; waitrequest = 1'b0;
    // JR to zero, then delay-slot ADDU, then halt
    fetch(32'h00200008, 32'h00000500);
    rs_data = 32'd0; #1;
    chk("jr0_cond", 32'(PCWriteCond), 32'd1);
    chk("jr0_target", pc_prev, 32'd0);
    to_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step;
    chk("jr0_wb_to_fetch", 32'(state), 32'd0);
    chk("jr0_still_active", 32'(active), 32'd1);
    fetch(32'h00221821, 32'h00000508);
    #1; chk("addu_no_cond", 32'(PCWriteCond), 32'd0);
    to_wb(1'b1, 1'b0, 5'd0, 32'd0);
    step;
    chk("halt_state", 32'(state), 32'd5);
    chk("halt_active", 32'(active), 32'd0);
    waitrequest = 1'b0; #1;
    chk("halt_no_pcctl", 32'(pcctl), 32'd0);
    step; step;
    chk("halt_terminal", 32'(state), 32'd5);
    chk("halt_pc_prev", pc_prev, 32'd0);
    // misaligned JR target
    reset = 1'b1; step; reset = 1'b0;
    chk("rst_after_halt", 32'(active), 32'd1);
    fetch(32'h00200008, 32'h00000600);
    rs_data = 32'h00000402; #1;
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_no_cond", 32'(PCWriteCond), 32'd0);
    chk("mis_pc_prev", pc_prev, 32'd0);
    step;
    chk("mis_halted", 32'(state), 32'd5);
    chk("mis_err", 32'(misaligned_err), 32'd1);
`else
    chk("mis_cond", 32'(PCWriteCond), 32'd1);
    chk("mis_forced_target", pc_prev, 32'h00000400);
    step;
    chk("mis_continue", 32'(state), 32'd3);
    chk("mis_err_tied", 32'(misaligned_err), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
